drum_audio_bridge: RTL



---
 rtl/drum_audio_bridge.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/drum_audio_bridge.sv
// drum_audio_bridge: buffers centre-node samples from the drum-grid solver and
// delivers each one as a left/right codec pair to the audio-core FIFO over the bus.
module drum_audio_bridge #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          GAIN_SHIFT = 2,
  parameter logic [31:0] SPACE_ADDR = 32'h0000_0044,
  parameter logic [31:0] LEFT_ADDR  = 32'h0000_0048,
  parameter logic [31:0] RIGHT_ADDR = 32'h0000_004C
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic [17:0] sample_in,
  input  logic        sample_valid,
  output logic        grid_go,
  output logic [31:0] bus_addr,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  input  logic [31:0] bus_readdata,
  input  logic        bus_ack,
  output logic [15:0] drop_cnt,
  output logic [31:0] sent_cnt
);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          TW    = 18 + GAIN_SHIFT;
  localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {IDLE, RD_SPACE, CHECK, WR_L, WR_R} state_t;

  state_t             state, state_next;
  logic               gap;
  logic [7:0]         wsrc, wslc;
  logic [17:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [AW:0]        count, count_next;
  logic               strobe, ack_taken, push, pop;
  logic signed [17:0] head;
  logic signed [TW-1:0] t_wide;
  logic [17:0]        t_sat;
  logic [15:0]        s16;
  logic [31:0]        conv_data;
  logic               unused_readdata;

  assign unused_readdata = ^bus_readdata[15:0];

  // gap forces one strobe-free cycle after every completed access
  assign strobe    = (state == RD_SPACE || state == WR_L || state == WR_R) && !gap;
  assign ack_taken = strobe && bus_ack;
  assign pop       = (state == WR_R) && ack_taken;
  assign push      = sample_valid && ((count < DEPTH) || pop);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk_50) begin
    if (push)
      mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      grid_go  <= 1'b0;
      drop_cnt <= '0;
      sent_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        sent_cnt <= sent_cnt + 32'd1;
      end
      if (sample_valid && !push && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      count   <= count_next;
      grid_go <= (count_next < DEPTH);
    end
  end

  // Head conversion: gain, saturate to 1.17, keep the top 16 bits
  assign head   = mem[rd_ptr];
  assign t_wide = TW'(head) <<< GAIN_SHIFT;

  always_comb begin
    t_sat = t_wide[17:0];
    if (t_wide[TW-1:17] != {(TW-17){t_wide[TW-1]}})
      t_sat = t_wide[TW-1] ? 18'h20000 : 18'h1FFFF;
  end

  assign s16       = t_sat[17:2];
  assign conv_data = {{16{s16[15]}}, s16};

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state <= IDLE;
      gap   <= 1'b0;
      wsrc  <= '0;
      wslc  <= '0;
    end else begin
      state <= state_next;
      gap   <= ack_taken;
      if (state == RD_SPACE && ack_taken) begin
        wsrc <= bus_readdata[31:24];
        wslc <= bus_readdata[23:16];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (count != '0) state_next = RD_SPACE;
      RD_SPACE: if (ack_taken) state_next = CHECK;
      CHECK:    if (!gap) state_next = (wsrc != 8'd0 && wslc != 8'd0) ? WR_L : RD_SPACE;
      WR_L:     if (ack_taken) state_next = WR_R;
      WR_R:     if (ack_taken) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_addr      = '0;
    bus_read      = 1'b0;
    bus_write     = 1'b0;
    bus_writedata = '0;
    if (!gap) begin
      case (state)
        RD_SPACE: begin
          bus_addr = SPACE_ADDR;
          bus_read = 1'b1;
        end
        WR_L: begin
          bus_addr      = LEFT_ADDR;
          bus_write     = 1'b1;
          bus_writedata = conv_data;
        end
        WR_R: begin
          bus_addr      = RIGHT_ADDR;
          bus_write     = 1'b1;
          bus_writedata = conv_data;
        end
        default: ;
      endcase
    end
  end

endmodule
